// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups
// with a flattened second-level lookahead across groups and valid/ready handshaking.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);

  localparam int unsigned NumGroups = WIDTH / 4;

  // Carry into position pos from generate/propagate vectors and a carry in, written as a
  // sum of products so no term depends on a lower-position carry.
  function automatic logic lookahead(input logic [15:0] gen, input logic [15:0] prop,
                                     input logic c_in, input int unsigned pos);
    logic res;
    logic term;
    res = 1'b0;
    for (int unsigned j = 0; j < 16; j++) begin
      if (j < pos) begin
        term = gen[j];
        for (int unsigned m = 0; m < 16; m++) begin
          if (m > j && m < pos) term = term & prop[m];
        end
        res = res | term;
      end
    end
    term = c_in;
    for (int unsigned m = 0; m < 16; m++) begin
      if (m < pos) term = term & prop[m];
    end
    return res | term;
  endfunction

  logic                 s2_adv, s1_adv, accept;
  logic                 s1_valid_d, s1_valid_q, out_valid_d, out_valid_q;

  logic [WIDTH-1:0]     bb, p_new, g_new;
  logic [NumGroups-1:0] grp_p_new, grp_g_new;
  logic                 c0_new;

  logic [WIDTH-1:0]     p_d, p_q, g_d, g_q;
  logic [NumGroups-1:0] grp_p_d, grp_p_q, grp_g_d, grp_g_q;
  logic                 c0_d, c0_q;

  logic [NumGroups:0]   grp_c;
  logic [WIDTH-1:0]     c_bit;
  logic [15:0]          grpp_pad, grpg_pad, bitp_pad, bitg_pad;
  logic [WIDTH-1:0]     sum_new;
  logic                 cout_new, ovf_new, pg_new, gg_new;

  logic [WIDTH-1:0]     sum_d, sum_q;
  logic                 cout_d, cout_q, ovf_d, ovf_q, pg_d, pg_q, gg_d, gg_q;

  // Handshake: ready flows combinationally from out_ready back to in_ready.
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    in_ready    = !rst && s1_adv;
    accept      = in_valid && in_ready;
    s1_valid_d  = s1_adv ? accept : s1_valid_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
  end

  // Stage 1: effective operands, bit p/g and 4-bit group P/G.
  always_comb begin
    bb        = sub ? ~b : b;
    c0_new    = sub | cin;
    p_new     = a ^ bb;
    g_new     = a & bb;
    grp_p_new = '0;
    grp_g_new = '0;
    for (int unsigned k = 0; k < NumGroups; k++) begin
      grp_p_new[k] = &p_new[4*k +: 4];
      grp_g_new[k] = g_new[4*k+3]
                   | (p_new[4*k+3] & g_new[4*k+2])
                   | (p_new[4*k+3] & p_new[4*k+2] & g_new[4*k+1])
                   | (p_new[4*k+3] & p_new[4*k+2] & p_new[4*k+1] & g_new[4*k]);
    end
    p_d     = accept ? p_new : p_q;
    g_d     = accept ? g_new : g_q;
    grp_p_d = accept ? grp_p_new : grp_p_q;
    grp_g_d = accept ? grp_g_new : grp_g_q;
    c0_d    = accept ? c0_new : c0_q;
  end

  // Stage 2: group carries, then bit carries inside each group from that group's carry.
  always_comb begin
    grpp_pad = '0;
    grpg_pad = '0;
    grpp_pad[NumGroups-1:0] = grp_p_q;
    grpg_pad[NumGroups-1:0] = grp_g_q;
    grp_c    = '0;
    grp_c[0] = c0_q;
    for (int unsigned k = 1; k <= NumGroups; k++) begin
      grp_c[k] = lookahead(grpg_pad, grpp_pad, c0_q, k);
    end
    c_bit = '0;
    for (int unsigned k = 0; k < NumGroups; k++) begin
      bitp_pad      = '0;
      bitg_pad      = '0;
      bitp_pad[3:0] = p_q[4*k +: 4];
      bitg_pad[3:0] = g_q[4*k +: 4];
      for (int unsigned i = 0; i < 4; i++) begin
        c_bit[4*k+i] = lookahead(bitg_pad, bitp_pad, grp_c[k], i);
      end
    end
    sum_new  = p_q ^ c_bit;
    cout_new = grp_c[NumGroups];
    ovf_new  = c_bit[WIDTH-1] ^ cout_new;
    pg_new   = &grp_p_q;
    gg_new   = lookahead(grpg_pad, grpp_pad, 1'b0, NumGroups);

    // Output register only loads when a beat actually moves in.
    if (s2_adv && s1_valid_q) begin
      sum_d  = sum_new;
      cout_d = cout_new;
      ovf_d  = ovf_new;
      pg_d   = pg_new;
      gg_d   = gg_new;
    end else begin
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      pg_d   = pg_q;
      gg_d   = gg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      grp_p_q     <= '0;
      grp_g_q     <= '0;
      c0_q        <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pg_q        <= 1'b0;
      gg_q        <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      grp_p_q     <= grp_p_d;
      grp_g_q     <= grp_g_d;
      c0_q        <= c0_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      pg_q        <= pg_d;
      gg_q        <= gg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign pg        = pg_q;
  assign gg        = gg_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: 16-bit vector table through a scoreboard, backpressure and reset
// sequences, and a random width sweep against a behavioural A+/-B reference.
module tb_cla_pipe_adder;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        pg;
    logic        gg;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } beat_t;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf, pg, gg;

  logic [63:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_valid, sw_ordy;
  logic        w4_rdy, w4_ov, w4_cout, w4_ovf, w4_pg, w4_gg;
  logic        w8_rdy, w8_ov, w8_cout, w8_ovf, w8_pg, w8_gg;
  logic        w32_rdy, w32_ov, w32_cout, w32_ovf, w32_pg, w32_gg;
  logic        w64_rdy, w64_ov, w64_cout, w64_ovf, w64_pg, w64_gg;
  logic [3:0]  w4_sum;
  logic [7:0]  w8_sum;
  logic [31:0] w32_sum;
  logic [63:0] w64_sum;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  exp_t  sb[$];
  beat_t pend[$];
  beat_t vec[12];

  cla_pipe_adder #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .pg(pg), .gg(gg)
  );

  cla_pipe_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w4_rdy), .a(sw_a[3:0]),
    .b(sw_b[3:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(w4_ov), .out_ready(sw_ordy),
    .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf), .pg(w4_pg), .gg(w4_gg)
  );

  cla_pipe_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w8_rdy), .a(sw_a[7:0]),
    .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(w8_ov), .out_ready(sw_ordy),
    .sum(w8_sum), .cout(w8_cout), .ovf(w8_ovf), .pg(w8_pg), .gg(w8_gg)
  );

  cla_pipe_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w32_rdy), .a(sw_a[31:0]),
    .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(w32_ov), .out_ready(sw_ordy),
    .sum(w32_sum), .cout(w32_cout), .ovf(w32_ovf), .pg(w32_pg), .gg(w32_gg)
  );

  cla_pipe_adder #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w64_rdy), .a(sw_a),
    .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(w64_ov), .out_ready(sw_ordy),
    .sum(w64_sum), .cout(w64_cout), .ovf(w64_ovf), .pg(w64_pg), .gg(w64_gg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                               input logic ts, input logic [15:0] es, input logic ec,
                               input logic eo, input logic ep, input logic eg);
    beat_t r;
    r.a      = ta;
    r.b      = tb;
    r.cin    = tc;
    r.sub    = ts;
    r.e.sum  = 64'(es);
    r.e.cout = ec;
    r.e.ovf  = eo;
    r.e.pg   = ep;
    r.e.gg   = eg;
    return r;
  endfunction

  function automatic exp_t model(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                 input logic tc, input logic ts);
    exp_t        r;
    logic [63:0] mask, am, bm;
    logic [64:0] full, gfull;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am     = ta & mask;
    bm     = (ts ? ~tb : tb) & mask;
    full   = {1'b0, am} + {1'b0, bm} + {64'd0, (ts | tc)};
    gfull  = {1'b0, am} + {1'b0, bm};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
    r.pg   = ((am ^ bm) & mask) == mask;
    r.gg   = gfull[w];
    return r;
  endfunction

  // One cycle on the 16-bit DUT: drive at negedge, then observe both handshakes.
  task automatic run_cycle(input logic ordy);
    exp_t e;
    @(negedge clk);
    out_ready = ordy;
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      a        = pend[0].a;
      b        = pend[0].b;
      cin      = pend[0].cin;
      sub      = pend[0].sub;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got sum %0h, required no beat", sum);
      end else begin
        e = sb.pop_front();
        chk("sum", 64'(sum), e.sum);
        chk("cout", 64'(cout), 64'(e.cout));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("pg", 64'(pg), 64'(e.pg));
        chk("gg", 64'(gg), 64'(e.gg));
        n_pops++;
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(pend[0].e);
      void'(pend.pop_front());
    end
  endtask

  task automatic chk_w(input string nm, input int w, input logic ov, input logic [63:0] s,
                       input logic co, input logic of, input logic p, input logic g);
    exp_t m;
    m = model(w, sw_a, sw_b, sw_cin, sw_sub);
    chk({nm, "_valid"}, 64'(ov), 64'd1);
    chk({nm, "_sum"}, s, m.sum);
    chk({nm, "_cout"}, 64'(co), 64'(m.cout));
    chk({nm, "_ovf"}, 64'(of), 64'(m.ovf));
    chk({nm, "_pg"}, 64'(p), 64'(m.pg));
    chk({nm, "_gg"}, 64'(g), 64'(m.gg));
  endtask

  task automatic sweep_one(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                           input logic ts);
    @(negedge clk);
    sw_a     = ta;
    sw_b     = tb;
    sw_cin   = tc;
    sw_sub   = ts;
    sw_valid = 1'b1;
    #1;
    chk("sweep_in_ready", 64'({w4_rdy, w8_rdy, w32_rdy, w64_rdy}), 64'hF);
    @(negedge clk);
    sw_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_w("w4", 4, w4_ov, 64'(w4_sum), w4_cout, w4_ovf, w4_pg, w4_gg);
    chk_w("w8", 8, w8_ov, 64'(w8_sum), w8_cout, w8_ovf, w8_pg, w8_gg);
    chk_w("w32", 32, w32_ov, 64'(w32_sum), w32_cout, w32_ovf, w32_pg, w32_gg);
    chk_w("w64", 64, w64_ov, w64_sum, w64_cout, w64_ovf, w64_pg, w64_gg);
  endtask

  initial begin
    int cyc;
    int p0;

    //            a        b        cin   sub   sum      cout  ovf   pg    gg
    vec[0]  = mk(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    vec[1]  = mk(16'hFFFF, 16'h000A, 1'b1, 1'b0, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b1);
    vec[2]  = mk(16'h0004, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
    vec[3]  = mk(16'h0004, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
    vec[4]  = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    vec[5]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
    vec[6]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    vec[7]  = mk(16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    vec[8]  = mk(16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vec[9]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    vec[10] = mk(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h68AC, 1'b0, 1'b0, 1'b0, 1'b0);
    vec[11] = mk(16'h00FF, 16'h00FF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    sw_a      = '0;
    sw_b      = '0;
    sw_cin    = 1'b0;
    sw_sub    = 1'b0;
    sw_valid  = 1'b0;
    sw_ordy   = 1'b1;

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, ovf, pg, gg}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Latency: result visible after the second edge following the offer cycle.
    pend.push_back(vec[0]);
    run_cycle(1'b1);
    run_cycle(1'b1);
    chk("latency_edge1_out_valid", 64'(out_valid), 64'd0);
    p0 = n_pops;
    run_cycle(1'b1);
    chk("latency_edge2_pop", 64'(n_pops - p0), 64'd1);

    // Back-to-back table stream at full throughput.
    for (int i = 1; i < 12; i++) pend.push_back(vec[i]);
    cyc = 0;
    while ((pend.size() > 0 || sb.size() > 0) && cyc < 100) begin
      run_cycle(1'b1);
      cyc++;
    end
    chk("stream_cycles", 64'(cyc), 64'd13);

    // Backpressure: hold out_ready low for 3 cycles once the first result is up.
    for (int i = 1; i <= 4; i++) begin
      pend.push_back(mk(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0, 1'b0, 1'b0, 1'b0));
    end
    run_cycle(1'b1);
    run_cycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'h2);
    end
    p0  = n_pops;
    cyc = 0;
    while ((pend.size() > 0 || sb.size() > 0) && cyc < 100) begin
      run_cycle(1'b1);
      cyc++;
    end
    chk("release_pops", 64'(n_pops - p0), 64'd4);
    chk("release_cycles", 64'(cyc), 64'd4);

    // Asynchronous reset with two beats in flight.
    pend.push_back(mk(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0));
    pend.push_back(mk(16'h0200, 16'h0200, 1'b0, 1'b0, 16'h0400, 1'b0, 1'b0, 1'b0, 1'b0));
    run_cycle(1'b1);
    run_cycle(1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sum", 64'(sum), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    pend.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rerelease_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1);
      chk("no_stale_out_valid", 64'(out_valid), 64'd0);
    end
    pend.push_back(mk(16'h0005, 16'h0006, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0));
    p0  = n_pops;
    cyc = 0;
    while ((pend.size() > 0 || sb.size() > 0) && cyc < 20) begin
      run_cycle(1'b1);
      cyc++;
    end
    chk("post_rst_pops", 64'(n_pops - p0), 64'd1);
    chk("drain_empty", 64'(pend.size() + sb.size()), 64'd0);

    // Width sweep, including all-ones carry-chain corners.
    sweep_one('1, 64'd1, 1'b0, 1'b0);
    sweep_one('1, '1, 1'b1, 1'b0);
    sweep_one('0, 64'd1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      sweep_one({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
